fpu_result_queue: RTL and testbench

FPU_RESULT_QUEUE -- requirements
Module: fpu_result_queue

---
 rtl/fpu_result_queue.sv | 155 +++++++++++++++
 tb/tb_fpu_result_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_queue.sv
// fpu_result_queue: first-word-fall-through queue of completed FPU results.
// It keeps accrued exception flags (fflags), a sticky overflow indicator for
// dropped results, and an occupancy-based service request.
// Optional feature: define FPU_RQ_TIMESTAMP_EN to stamp each entry with a
// free-running 16-bit cycle count, presented on rd_ts.
module fpu_result_queue #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned IRQ_THRESH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     res_valid,
  input  logic [31:0]              res_data,
  input  logic [4:0]               res_exc,
  input  logic [10:0]              res_opsel,
  input  logic                     rd_en,
  input  logic                     flags_clr,
  output logic                     rd_valid,
  output logic [31:0]              rd_data,
  output logic [4:0]               rd_exc,
  output logic [3:0]               rd_unit,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [4:0]               flags,
  output logic                     overflow,
`ifdef FPU_RQ_TIMESTAMP_EN
  output logic [15:0]              rd_ts,
`endif
  output logic                     irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef FPU_RQ_TIMESTAMP_EN
  localparam int unsigned EW = 57;
`else
  localparam int unsigned EW = 41;
`endif

  // Entry layout, low to high: unit[3:0], exc[8:4], data[40:9], optional ts[56:41].
  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    flags_q, flags_d;
  logic          overflow_q, overflow_d;

  logic          push, pop, drop;
  logic          is_full, is_empty;
  logic [3:0]    unit_enc;
  logic [EW-1:0] new_entry;
  logic [EW-1:0] head_entry;

`ifdef FPU_RQ_TIMESTAMP_EN
  logic [15:0] ts_q;

  // Free-running cycle counter; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 16'd1;
  end
`endif

  // Lowest set bit of the one-hot select wins; no bit set encodes 4'hF.
  always_comb begin
    unit_enc = 4'hF;
    for (int i = 10; i >= 0; i--) begin
      if (res_opsel[i]) unit_enc = 4'(i);
    end
  end

  // Queue control: a pop while full frees the slot the same-cycle push uses.
  always_comb begin
    is_full  = (count_q == CW'(DEPTH));
    is_empty = (count_q == '0);
    push     = res_valid && (!is_full || rd_en);
    pop      = rd_en && !is_empty;
    drop     = res_valid && is_full && !rd_en;
`ifdef FPU_RQ_TIMESTAMP_EN
    new_entry = {ts_q, res_data, res_exc, unit_enc};
`else
    new_entry = {res_data, res_exc, unit_enc};
`endif
  end

  // Next-state for pointers, occupancy and sticky status.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    flags_d    = flags_q;
    overflow_d = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A clear in the same cycle as a new result keeps only that result's status.
    if (flags_clr) begin
      flags_d    = res_valid ? res_exc : 5'b0;
      overflow_d = drop;
    end else begin
      if (res_valid) flags_d = flags_q | res_exc;
      if (drop)      overflow_d = 1'b1;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      flags_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flags_q    <= flags_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr_q] <= new_entry;
  end

  // Head presentation and status outputs, all from registered state.
  always_comb begin
    head_entry = is_empty ? '0 : mem[rd_ptr_q];
    rd_valid   = !is_empty;
    rd_unit    = head_entry[3:0];
    rd_exc     = head_entry[8:4];
    rd_data    = head_entry[40:9];
`ifdef FPU_RQ_TIMESTAMP_EN
    rd_ts      = head_entry[56:41];
`endif
    count      = count_q;
    full       = is_full;
    empty      = is_empty;
    flags      = flags_q;
    overflow   = overflow_q;
    irq        = (count_q >= CW'(IRQ_THRESH)) | overflow_q;
  end

endmodule

// File: tb/tb_fpu_result_queue.sv
// tb_fpu_result_queue: directed and randomized checks against a queue-based model.
module tb_fpu_result_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, res_valid, rd_en, flags_clr;
  logic [31:0] res_data;
  logic [4:0]  res_exc;
  logic [10:0] res_opsel;
  logic        rd_valid, full, empty, overflow, irq;
  logic [31:0] rd_data;
  logic [4:0]  rd_exc, flags;
  logic [3:0]  rd_unit;
  logic [3:0]  count;
`ifdef FPU_RQ_TIMESTAMP_EN
  logic [15:0] rd_ts;
`endif

  always #5 clk = ~clk;

  fpu_result_queue #(.DEPTH(DEPTH), .IRQ_THRESH(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_exc   (res_exc),
    .res_opsel (res_opsel),
    .rd_en     (rd_en),
    .flags_clr (flags_clr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_exc    (rd_exc),
    .rd_unit   (rd_unit),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .flags     (flags),
    .overflow  (overflow),
`ifdef FPU_RQ_TIMESTAMP_EN
    .rd_ts     (rd_ts),
`endif
    .irq       (irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of {data, exc, unit} plus sticky status.
  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  exc;
    logic [3:0]  unit;
  } entry_t;

  entry_t     mq[$];
  logic [4:0] m_flags = '0;
  logic       m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] unit_of(input logic [10:0] op);
    for (int i = 0; i < 11; i++) if (op[i]) return 4'(i);
    return 4'hF;
  endfunction

  // Apply the rules to the inputs present at the clock edge.
  task automatic model_step();
    bit was_full, was_empty, do_push, do_pop, do_drop;
    entry_t e;
    if (rst) begin
      mq.delete();
      m_flags = '0;
      m_ovf   = 1'b0;
      return;
    end
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    do_pop    = rd_en && !was_empty;
    do_push   = res_valid && (!was_full || rd_en);
    do_drop   = res_valid && was_full && !rd_en;
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      e.data = res_data;
      e.exc  = res_exc;
      e.unit = unit_of(res_opsel);
      mq.push_back(e);
    end
    if (flags_clr) begin
      m_flags = res_valid ? res_exc : 5'b0;
      m_ovf   = do_drop;
    end else begin
      if (res_valid) m_flags = m_flags | res_exc;
      if (do_drop)   m_ovf = 1'b1;
    end
  endtask

  task automatic compare_all();
    entry_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    check("rd_valid", rd_valid, mq.size() != 0);
    check("rd_data", rd_data, h.data);
    check("rd_exc", rd_exc, h.exc);
    check("rd_unit", rd_unit, h.unit);
    check("count", count, mq.size());
    check("full", full, mq.size() == DEPTH);
    check("empty", empty, mq.size() == 0);
    check("flags", flags, m_flags);
    check("overflow", overflow, m_ovf);
    check("irq", irq, (mq.size() >= 1) || m_ovf);
  endtask

  task automatic cycle(input logic r, input logic v, input logic [31:0] d, input logic [4:0] e,
                       input logic [10:0] op, input logic rd, input logic clr);
    rst = r; res_valid = v; res_data = d; res_exc = e; res_opsel = op;
    rd_en = rd; flags_clr = clr;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 5'h0, 11'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'h0, 5'h0, 11'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int rd_pct;
    logic [10:0] op;

    // Reset then idle.
    do_reset();
    idle();
    check("reset_empty", empty, 1'b1);
    check("reset_irq", irq, 1'b0);
    check("reset_rd_data", rd_data, 32'h0);

    // Single push of 1.0 from the mul unit, then pop.
    cycle(1'b0, 1'b1, 32'h3F80_0000, 5'b00001, 11'b000_0100_0000, 1'b0, 1'b0);
    check("single_unit", rd_unit, 4'd6);
    check("single_irq", irq, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 5'h0, 11'h0, 1'b1, 1'b0);
    check("single_empty_after_pop", empty, 1'b1);
    check("single_flags", flags, 5'b00001);

    // Fill past capacity: the ninth result is dropped.
    cycle(1'b0, 1'b0, 32'h0, 5'h0, 11'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) cycle(1'b0, 1'b1, i, 5'h0, 11'h1, 1'b0, 1'b0);
    check("fill_full", full, 1'b1);
    check("fill_overflow", overflow, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      check("fill_order", rd_data, i);
      cycle(1'b0, 1'b0, 32'h0, 5'h0, 11'h0, 1'b1, 1'b0);
    end
    check("drain_empty", empty, 1'b1);

    // Push and pop together while full.
    cycle(1'b0, 1'b0, 32'h0, 5'h0, 11'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 32'h100 + i, 5'h0, 11'h2, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'hABCD, 5'h0, 11'h4, 1'b1, 1'b0);
    check("full_pushpop_count", count, 4'd8);
    check("full_pushpop_head", rd_data, 32'h101);
    check("full_pushpop_ovf", overflow, 1'b0);

    // Push and pop together while empty: entry kept, no bypass.
    do_reset();
    cycle(1'b0, 1'b1, 32'h55, 5'h0, 11'h8, 1'b1, 1'b0);
    check("empty_pushpop_count", count, 4'd1);
    check("empty_pushpop_data", rd_data, 32'h55);
    cycle(1'b0, 1'b1, 32'h66, 5'b10000, 11'h10, 1'b0, 1'b1);
    check("clr_load_flags", flags, 5'b10000);

    // Pointer wrap with 20 pushes, then reset with 3 entries queued.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 32'h200 + i, 5'h0, 11'h400, i >= 3, 1'b0);
    check("wrap_count", count, 4'd3);
    check("wrap_head", rd_data, 32'h200 + 17);
    cycle(1'b1, 1'b1, 32'h999, 5'h1F, 11'h1, 1'b1, 1'b1);
    check("midreset_empty", empty, 1'b1);
    check("midreset_flags", flags, 5'h0);
    check("midreset_rd_data", rd_data, 32'h0);

    // Randomized traffic with drifting pop pressure to visit full and empty.
    for (int n = 0; n < 800; n++) begin
      if (n % 100 == 0) rd_pct = $urandom_range(10, 90);
      case ($urandom_range(0, 3))
        0:       op = 11'h0;
        1:       op = 11'($urandom);
        default: op = 11'(1) << $urandom_range(0, 10);
      endcase
      cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 99) < 60), $urandom,
            5'($urandom), op, ($urandom_range(0, 99) < rd_pct),
            ($urandom_range(0, 24) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
